parking_gate_ctrl: RTL and testbench

//  Entry-barrier controller downstream of the parking occupancy counter.

---
 rtl/parking_pkg.sv | 26 ++
 rtl/parking_edge_det.sv | 24 ++
 rtl/parking_gate_ctrl.sv | 145 ++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking entry barrier controller.
// Exports gate_state_t, default parameters and the timer width helper.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAISE,
    UP,
    LOWER
  } gate_state_t;

  localparam int unsigned DEF_CAPACITY     = 100;
  localparam int unsigned DEF_TRAVEL_CYC   = 16;
  localparam int unsigned DEF_HOLD_TIMEOUT = 200;

  // Width able to hold max(t,h)-1; at least 1 bit.
  function automatic int unsigned tmr_w(
    input int unsigned t,
    input int unsigned h
  );
    int unsigned m;
    m = (t > h) ? t : h;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/parking_edge_det.sv
// Registered 1-bit rise/fall detector.
// Ports: clk, reset (sync, high), d in; rise/fall = d vs previous sample.
module parking_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry barrier controller: grants/denies requests against CAPACITY
// and sequences the barrier motor (raise, hold, lower, safety reverse).
// Ports: clk, reset (sync, high), count[7:0], req, a (entry sensor);
//   grant/denied pulses, gate_drive, gate_up, full, free_slots[7:0].
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY     = DEF_CAPACITY,
  parameter int unsigned TRAVEL_CYC   = DEF_TRAVEL_CYC,
  parameter int unsigned HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] count,
  input  logic       req,
  input  logic       a,
  output logic       grant,
  output logic       denied,
  output logic       gate_drive,
  output logic       gate_up,
  output logic       full,
  output logic [7:0] free_slots
);

  localparam int unsigned TW = tmr_w(TRAVEL_CYC, HOLD_TIMEOUT);

  localparam logic [TW-1:0] TRAVEL_END = TW'(TRAVEL_CYC - 1);
  localparam logic [TW-1:0] HOLD_END   = TW'(HOLD_TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [7:0]    CAP8       = 8'(CAPACITY);

  gate_state_t   state;
  gate_state_t   state_nx;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nx;
  logic          grant_nx;
  logic          denied_nx;

  logic req_rise;
  logic req_fall_unused;
  logic a_rise;
  logic a_fall;

  parking_edge_det u_req_ed (
    .clk  (clk),
    .reset(reset),
    .d    (req),
    .rise (req_rise),
    .fall (req_fall_unused)
  );

  parking_edge_det u_a_ed (
    .clk  (clk),
    .reset(reset),
    .d    (a),
    .rise (a_rise),
    .fall (a_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      full       <= 1'b0;
      free_slots <= CAP8;
    end else begin
      full       <= (count >= CAP8);
      free_slots <= (count >= CAP8) ? 8'd0 : CAP8 - count;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      grant  <= 1'b0;
      denied <= 1'b0;
    end else begin
      state  <= state_nx;
      timer  <= timer_nx;
      grant  <= grant_nx;
      denied <= denied_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    grant_nx  = 1'b0;
    denied_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_rise) begin
          if (full) begin
            denied_nx = 1'b1;
          end else begin
            grant_nx = 1'b1;
            state_nx = RAISE;
            timer_nx = '0;
          end
        end
      end
      RAISE: begin
        if (timer == TRAVEL_END) begin
          state_nx = UP;
          timer_nx = '0;
        end else begin
          timer_nx = timer + T_ONE;
        end
      end
      UP: begin
        if (a_fall) begin
          state_nx = LOWER;
          timer_nx = '0;
        end else if (timer == HOLD_END) begin
          // Timer parks here while a car still blocks the sensor.
          if (!a) begin
            state_nx = LOWER;
            timer_nx = '0;
          end
        end else begin
          timer_nx = timer + T_ONE;
        end
      end
      LOWER: begin
        // Reverse beats travel-complete: full raise is redone.
        if (a_rise) begin
          state_nx = RAISE;
          timer_nx = '0;
        end else if (timer == TRAVEL_END) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + T_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  assign gate_drive = (state == RAISE) || (state == UP);
  assign gate_up    = (state == UP);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed scenarios plus
// randomized traffic checked against a cycle-level behavioural model.
module tb_parking_gate_ctrl;

  localparam int CAP = 4;
  localparam int TRV = 4;
  localparam int HLD = 20;

  localparam int PH_IDLE  = 0;
  localparam int PH_RISE  = 1;
  localparam int PH_OPEN  = 2;
  localparam int PH_FALL  = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] count;
  logic       req;
  logic       a;
  logic       grant;
  logic       denied;
  logic       gate_drive;
  logic       gate_up;
  logic       full;
  logic [7:0] free_slots;

  int checks = 0;
  int errors = 0;

  // Reference model: phase plus cycles spent in it.
  int ph      = PH_IDLE;
  int spent   = 0;
  bit m_req_q = 0;
  bit m_a_q   = 0;
  bit e_full  = 0;
  int e_free  = CAP;
  bit e_grant = 0;
  bit e_deny  = 0;

  always #5 clk = ~clk;

  parking_gate_ctrl #(
    .CAPACITY    (CAP),
    .TRAVEL_CYC  (TRV),
    .HOLD_TIMEOUT(HLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .req       (req),
    .a         (a),
    .grant     (grant),
    .denied    (denied),
    .gate_drive(gate_drive),
    .gate_up   (gate_up),
    .full      (full),
    .free_slots(free_slots)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit pressed;
    bit car_in;
    bit car_out;
    pressed = req && !m_req_q;
    car_in  = a && !m_a_q;
    car_out = !a && m_a_q;
    e_grant = 0;
    e_deny  = 0;
    if (reset) begin
      ph      = PH_IDLE;
      spent   = 0;
      m_req_q = 0;
      m_a_q   = 0;
      e_full  = 0;
      e_free  = CAP;
      return;
    end
    if (ph == PH_IDLE) begin
      if (pressed && e_full) e_deny = 1;
      else if (pressed) begin
        e_grant = 1;
        ph = PH_RISE;
        spent = 0;
      end
    end else if (ph == PH_RISE) begin
      spent++;
      if (spent >= TRV) begin
        ph = PH_OPEN;
        spent = 0;
      end
    end else if (ph == PH_OPEN) begin
      spent++;
      if (car_out || (spent >= HLD && !a)) begin
        ph = PH_FALL;
        spent = 0;
      end
    end else begin
      spent++;
      if (car_in) begin
        ph = PH_RISE;
        spent = 0;
      end else if (spent >= TRV) begin
        ph = PH_IDLE;
        spent = 0;
      end
    end
    e_full  = (int'(count) >= CAP);
    e_free  = e_full ? 0 : CAP - int'(count);
    m_req_q = req;
    m_a_q   = a;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("grant", 8'(grant), 8'(e_grant));
    chk("denied", 8'(denied), 8'(e_deny));
    chk("drive", 8'(gate_drive),
        8'(ph == PH_RISE || ph == PH_OPEN));
    chk("up", 8'(gate_up), 8'(ph == PH_OPEN));
    chk("full", 8'(full), 8'(e_full));
    chk("free", free_slots, 8'(e_free));
  endtask

  initial begin
    int ng;
    reset = 1'b1;
    req   = 1'b0;
    a     = 1'b0;
    count = 8'd0;
    cyc();
    cyc();
    chk("rst_free", free_slots, 8'd4);
    chk("rst_drive", 8'(gate_drive), 8'd0);
    reset = 1'b0;

    // 1: normal entry
    count = 8'd2;
    cyc();
    req = 1'b1;
    cyc();
    chk("t1_grant", 8'(grant), 8'd1);
    chk("t1_drive", 8'(gate_drive), 8'd1);
    req = 1'b0;
    repeat (3) begin
      cyc();
      chk("t1_rising", 8'(gate_up), 8'd0);
    end
    cyc();
    chk("t1_up", 8'(gate_up), 8'd1);
    a = 1'b1;
    repeat (3) cyc();
    chk("t1_car", 8'(gate_up), 8'd1);
    a = 1'b0;
    cyc();
    chk("t1_lower", 8'(gate_drive), 8'd0);
    repeat (4) cyc();
    chk("t1_free", free_slots, 8'd2);

    // 2: lot full
    count = 8'd4;
    cyc();
    chk("t2_full", 8'(full), 8'd1);
    req = 1'b1;
    cyc();
    chk("t2_denied", 8'(denied), 8'd1);
    chk("t2_nogrant", 8'(grant), 8'd0);
    chk("t2_drive", 8'(gate_drive), 8'd0);
    req = 1'b0;
    cyc();
    chk("t2_pulse", 8'(denied), 8'd0);
    count = 8'd6;
    cyc();
    chk("t2_over_free", free_slots, 8'd0);
    chk("t2_over_full", 8'(full), 8'd1);

    // 3: hold timeout, then timeout with car present
    count = 8'd1;
    cyc();
    req = 1'b1;
    cyc();
    req = 1'b0;
    repeat (4) cyc();
    chk("t3_up", 8'(gate_up), 8'd1);
    repeat (19) cyc();
    chk("t3_hold", 8'(gate_up), 8'd1);
    cyc();
    chk("t3_timeout", 8'(gate_up), 8'd0);
    repeat (4) cyc();
    req = 1'b1;
    cyc();
    req = 1'b0;
    repeat (4) cyc();
    a = 1'b1;
    repeat (25) cyc();
    chk("t3_held", 8'(gate_up), 8'd1);
    a = 1'b0;
    cyc();
    chk("t3_release", 8'(gate_up), 8'd0);
    repeat (4) cyc();

    // 4: safety reverse while lowering
    req = 1'b1;
    cyc();
    req = 1'b0;
    repeat (4) cyc();
    a = 1'b1;
    cyc();
    a = 1'b0;
    cyc();
    chk("t4_lower", 8'(gate_drive), 8'd0);
    repeat (2) cyc();
    a = 1'b1;
    cyc();
    chk("t4_reverse", 8'(gate_drive), 8'd1);
    repeat (3) cyc();
    chk("t4_rising", 8'(gate_up), 8'd0);
    cyc();
    chk("t4_up", 8'(gate_up), 8'd1);
    a = 1'b0;
    repeat (5) cyc();

    // 5: held request, then presses while busy
    count = 8'd0;
    cyc();
    req = 1'b1;
    ng = 0;
    repeat (50) begin
      cyc();
      if (grant) ng++;
    end
    chk("t5_one_grant", 8'(ng), 8'd1);
    req = 1'b0;
    cyc();
    req = 1'b1;
    cyc();
    req = 1'b0;
    repeat (10) begin
      req = 1'b1;
      cyc();
      chk("t5_ign_grant", 8'(grant), 8'd0);
      chk("t5_ign_deny", 8'(denied), 8'd0);
      req = 1'b0;
      cyc();
    end
    a = 1'b1;
    cyc();
    a = 1'b0;
    repeat (5) cyc();

    // 6: reset mid-raise
    count = 8'd2;
    req = 1'b1;
    cyc();
    req = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    chk("t6_drive", 8'(gate_drive), 8'd0);
    chk("t6_grant", 8'(grant), 8'd0);
    chk("t6_free", free_slots, 8'd4);
    reset = 1'b0;
    count = 8'd0;
    cyc();
    req = 1'b1;
    cyc();
    chk("t6_regrant", 8'(grant), 8'd1);
    req = 1'b0;
    repeat (30) cyc();

    // Randomized traffic
    repeat (4000) begin
      reset = ($urandom_range(0, 299) == 0);
      req   = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 5) == 0) a = ~a;
      if ($urandom_range(0, 15) == 0)
        count = 8'($urandom_range(0, 6));
      cyc();
    end
    reset = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
